lake_sram_fifo: RTL and testbench
=================================

// Module: lake_sram_fifo
// PURPOSE
//  Parametrised successor of the fixed 16-bit inner SRAM wrapper. On-chip dual-port SRAM
//  with internal write/read address generators, so the app graph drives only data and enables.
//  Sits between stencil stages (line buffer / stream buffer) in the CGRA memory tile path.
//  Adds configurable width, depth and read latency, occupancy, full/empty, sticky errors.
// PARAMETERS
//  DATA_WIDTH    16   width of data_in/data_out
//  DEPTH         512  number of words; any value 2..4096, need not be a power of two
//  ADDR_WIDTH    9    pointer width, = clog2(DEPTH)
//  READ_LATENCY  1    cycles from accepted read to valid_out; legal values 1 or 2
// PORTS
//  clk        in   1               single clock, all state on rising edge
//  rst        in   1               asynchronous, active-high reset
//  flush      in   1               synchronous clear of pointers, count, flags, pipeline
//  clk_en     in   1               1 = advance; 0 = freeze all state
//  wen_in     in   1               write request
//  data_in    in   DATA_WIDTH      write data, sampled when write accepted
//  ren_in     in   1               read request
//  data_out   out  DATA_WIDTH      read data
//  valid_out  out  1               data_out carries a new word this cycle
//  full       out  1               count == DEPTH
//  empty      out  1               count == 0
//  count      out  ADDR_WIDTH+1    words stored
//  overflow   out  1               sticky: write request rejected
//  underflow  out  1               sticky: read request rejected
// BEHAVIOUR
//  - Reset (async, any time): wptr=rptr=0, count=0, data_out=0, valid_out=0, empty=1, full=0,
//    overflow=underflow=0, read pipeline valids cleared. Memory contents undefined.
//  - Priority per edge: rst > flush > clk_en==0 > normal operation.
//  - flush (clk_en ignored): same values as reset except memory/data_out unchanged;
//    valid_out=0 next cycle; same-cycle wen_in/ren_in dropped, no flags set.
//  - clk_en==0: nothing changes; wen_in/ren_in ignored, no flags set, pipeline holds.
//  - Read accepted (rd_ok) = ren_in & !empty.
//  - Write accepted (wr_ok) = wen_in & (!full | rd_ok): write at full allowed if a read
//    is accepted the same cycle.
//  - Empty + simultaneous wen/ren: write accepted, read rejected (no bypass), underflow set.
//  - wr_ok: mem[wptr]<=data_in; wptr<=(wptr==DEPTH-1)?0:wptr+1. rd_ok: same wrap for rptr.
//  - count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both/neither; never exceeds DEPTH.
//  - full/empty/count are registered, reflect state after the edge.
//  - Read path: memory read registered at rptr on rd_ok; READ_LATENCY=1 -> data_out/valid_out
//    valid the cycle after rd_ok; =2 -> one extra output register, two cycles after.
//    Back-to-back reads give one word per cycle; data_out holds last word when valid_out=0.
//  - Same-address read/write in one cycle (only when count==DEPTH): read returns OLD word.
//  - wen_in & !wr_ok -> overflow<=1; ren_in & !rd_ok -> underflow<=1; cleared only by rst/flush.
//  - Reset asserted mid-read: in-flight words discarded, valid_out drops immediately.
// TESTING
//  1. DEPTH=4, write 0x11,0x22,0x33,0x44 -> full=1,count=4; 5th wen -> rejected, overflow=1.
//  2. Read 4 words, LAT=1 -> valid_out on cycles 1..4 after first ren, data 0x11..0x44, empty=1.
//  3. Full, wen+ren same cycle data 0x55 -> data_out=0x11, count stays 4, no overflow; later
//     drain ends with 0x55 (wrap of wptr 3->0 verified).
//  4. Empty, wen=ren=1 data 0xAA -> count=1, valid_out=0, underflow=1; next ren returns 0xAA.
//  5. LAT=2, DEPTH=5 (non-pow2): 12 streamed words, continuous ren after 2 -> in-order output,
//     valid_out 2 cycles after each rd_ok, pointers wrap 4->0.
//  6. count=3, flags set, flush with wen=1 -> count=0, empty=1, flags=0, no write; clk_en=0 with
//     wen/ren pulses -> no change; rst mid-stream -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/lake_sram_fifo.sv
// Dual-port SRAM FIFO with internal wrap-around pointers, registered occupancy/flags and sticky errors.
// Latency: READ_LATENCY (1 or 2) cycles from accepted read to valid_out; a write is readable the cycle after.
// Backpressure: none; a write to a full FIFO or a read from an empty one is dropped and sets a sticky flag.
module lake_sram_fifo #(
    parameter int DATA_WIDTH   = 16,
    parameter int DEPTH        = 512,
    parameter int ADDR_WIDTH   = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  clk_en,
    input  logic                  wen_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ren_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH-1:0] wptr_nxt;
    logic [ADDR_WIDTH-1:0] rptr_nxt;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  advance;
    logic                  rd_vld;
    logic [DATA_WIDTH-1:0] rd_dat;

    assign advance = clk_en & ~flush;
    assign rd_ok   = ren_in & ~empty;
    // A full FIFO still takes a write when a read frees a slot on the same edge.
    assign wr_ok   = wen_in & (~full | rd_ok);

    always_comb begin
        wptr_nxt  = wptr;
        rptr_nxt  = rptr;
        count_nxt = count;
        if (wr_ok) begin
            wptr_nxt = (wptr == LAST_ADDR) ? '0 : wptr + 1'b1;
        end
        if (rd_ok) begin
            rptr_nxt = (rptr == LAST_ADDR) ? '0 : rptr + 1'b1;
        end
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Storage is not reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (advance && wr_ok) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_vld    <= 1'b0;
            rd_dat    <= '0;
        end else if (flush) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            rd_vld    <= 1'b0;
        end else if (clk_en) begin
            wptr      <= wptr_nxt;
            rptr      <= rptr_nxt;
            count     <= count_nxt;
            full      <= (count_nxt == FULL_COUNT);
            empty     <= (count_nxt == '0);
            overflow  <= overflow | (wen_in & ~wr_ok);
            underflow <= underflow | (ren_in & ~rd_ok);
            rd_vld    <= rd_ok;
            // Non-blocking read of the slot being overwritten returns the old word.
            if (rd_ok) begin
                rd_dat <= mem[rptr];
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  out_vld;
            logic [DATA_WIDTH-1:0] out_dat;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld <= 1'b0;
                    out_dat <= '0;
                end else if (flush) begin
                    out_vld <= 1'b0;
                end else if (clk_en) begin
                    out_vld <= rd_vld;
                    if (rd_vld) begin
                        out_dat <= rd_dat;
                    end
                end
            end

            assign valid_out = out_vld;
            assign data_out  = out_dat;
        end else begin : g_lat1
            assign valid_out = rd_vld;
            assign data_out  = rd_dat;
        end
    endgenerate

endmodule

// File: tb/tb_lake_sram_fifo.sv
// Bench for lake_sram_fifo: DEPTH=4/LAT=1 and DEPTH=5/LAT=2 instances against a queue-based model.
module tb_lake_sram_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst;
    logic [1:0]  flush;
    logic [1:0]  clk_en;
    logic [1:0]  wen;
    logic [1:0]  ren;
    logic [15:0] din [2];

    logic [15:0] dout0, dout1;
    logic        vld0, vld1, full0, full1, empty0, empty1;
    logic        ovf0, ovf1, udf0, udf1;
    logic [2:0]  cnt0;
    logic [3:0]  cnt1;

    int errors = 0;
    int checks = 0;

    lake_sram_fifo #(.DATA_WIDTH(16), .DEPTH(4), .ADDR_WIDTH(2), .READ_LATENCY(1)) u0 (
        .clk(clk), .rst(rst[0]), .flush(flush[0]), .clk_en(clk_en[0]),
        .wen_in(wen[0]), .data_in(din[0]), .ren_in(ren[0]),
        .data_out(dout0), .valid_out(vld0), .full(full0), .empty(empty0),
        .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    lake_sram_fifo #(.DATA_WIDTH(16), .DEPTH(5), .ADDR_WIDTH(3), .READ_LATENCY(2)) u1 (
        .clk(clk), .rst(rst[1]), .flush(flush[1]), .clk_en(clk_en[1]),
        .wen_in(wen[1]), .data_in(din[1]), .ren_in(ren[1]),
        .data_out(dout1), .valid_out(vld1), .full(full1), .empty(empty1),
        .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    // Model: contents as a queue, plus the delayed read result per instance.
    int unsigned mq [2][$];
    bit          m_s1v [2];
    int unsigned m_s1d [2];
    bit          m_ov  [2];
    int unsigned m_od  [2];
    bit          m_ovf [2];
    bit          m_udf [2];
    int unsigned obs1 [$];
    logic [15:0] exp3 [4];

    function automatic int depth_of(int i);
        return (i == 0) ? 4 : 5;
    endfunction

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset(int i);
        mq[i].delete();
        m_s1v[i] = 1'b0;
        m_s1d[i] = 0;
        m_ov[i]  = 1'b0;
        m_od[i]  = 0;
        m_ovf[i] = 1'b0;
        m_udf[i] = 1'b0;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin : step
            bit          rd;
            bit          wr;
            int unsigned w;
            if (rst[i]) begin
                model_reset(i);
            end else if (flush[i]) begin
                mq[i].delete();
                m_s1v[i] = 1'b0;
                m_ov[i]  = 1'b0;
                m_ovf[i] = 1'b0;
                m_udf[i] = 1'b0;
            end else if (clk_en[i]) begin
                rd = ren[i] && (mq[i].size() > 0);
                wr = wen[i] && ((mq[i].size() < depth_of(i)) || rd);
                if (wen[i] && !wr) m_ovf[i] = 1'b1;
                if (ren[i] && !rd) m_udf[i] = 1'b1;
                w = 0;
                if (rd) w = mq[i].pop_front();
                if (wr) mq[i].push_back(din[i]);
                if (lat_of(i) == 1) begin
                    m_ov[i] = rd;
                    if (rd) m_od[i] = w;
                end else begin
                    m_ov[i] = m_s1v[i];
                    if (m_s1v[i]) m_od[i] = m_s1d[i];
                    m_s1v[i] = rd;
                    if (rd) m_s1d[i] = w;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst[0]) model_reset(0);
        if (rst[1]) model_reset(1);
        chk("u0_valid", vld0, m_ov[0]);
        chk("u0_data", dout0, m_od[0]);
        chk("u0_count", cnt0, mq[0].size());
        chk("u0_full", full0, mq[0].size() == 4);
        chk("u0_empty", empty0, mq[0].size() == 0);
        chk("u0_overflow", ovf0, m_ovf[0]);
        chk("u0_underflow", udf0, m_udf[0]);
        chk("u1_valid", vld1, m_ov[1]);
        chk("u1_data", dout1, m_od[1]);
        chk("u1_count", cnt1, mq[1].size());
        chk("u1_full", full1, mq[1].size() == 5);
        chk("u1_empty", empty1, mq[1].size() == 0);
        chk("u1_overflow", ovf1, m_ovf[1]);
        chk("u1_underflow", udf1, m_udf[1]);
        if (vld1 === 1'b1) obs1.push_back(dout1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(int i, bit w, bit r, logic [15:0] d);
        wen[i] = w;
        ren[i] = r;
        din[i] = d;
        cyc();
    endtask

    initial begin
        exp3[0] = 16'h22; exp3[1] = 16'h33; exp3[2] = 16'h44; exp3[3] = 16'h55;
        rst = 2'b11; flush = 2'b00; clk_en = 2'b11; wen = 2'b00; ren = 2'b00;
        din[0] = '0; din[1] = '0;
        cyc(); cyc();
        chk("rst_count", cnt0, 0);
        chk("rst_empty", empty0, 1);
        chk("rst_full", full0, 0);
        chk("rst_valid", vld0, 0);
        chk("rst_data", dout0, 0);
        chk("rst_data_lat2", dout1, 0);
        rst = 2'b00;

        // Fill to full, then a rejected write.
        drv(0, 1, 0, 16'h11); drv(0, 1, 0, 16'h22); drv(0, 1, 0, 16'h33); drv(0, 1, 0, 16'h44);
        chk("fill_count", cnt0, 4);
        chk("fill_full", full0, 1);
        drv(0, 1, 0, 16'h99);
        chk("ovf_set", ovf0, 1);
        chk("ovf_count", cnt0, 4);

        // Drain, one word per cycle.
        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 1, 16'h0);
            chk("drain_valid", vld0, 1);
            chk("drain_data", dout0, 16'h11 * k);
        end
        chk("drain_empty", empty0, 1);
        drv(0, 0, 0, 16'h0);
        chk("hold_valid", vld0, 0);
        chk("hold_data", dout0, 16'h44);

        // Empty with simultaneous write and read: no bypass.
        drv(0, 1, 1, 16'hAA);
        chk("nobypass_count", cnt0, 1);
        chk("nobypass_valid", vld0, 0);
        chk("nobypass_udf", udf0, 1);
        drv(0, 0, 1, 16'h0);
        chk("nobypass_data", dout0, 16'hAA);
        drv(0, 0, 0, 16'h0);
        flush[0] = 1'b1;
        cyc();
        flush[0] = 1'b0;
        chk("flush_ovf", ovf0, 0);
        chk("flush_udf", udf0, 0);

        // Write+read at full, then drain through the wrapped slot.
        drv(0, 1, 0, 16'h11); drv(0, 1, 0, 16'h22); drv(0, 1, 0, 16'h33); drv(0, 1, 0, 16'h44);
        drv(0, 1, 1, 16'h55);
        chk("fullrw_data", dout0, 16'h11);
        chk("fullrw_count", cnt0, 4);
        chk("fullrw_ovf", ovf0, 0);
        for (int k = 0; k < 4; k++) begin
            drv(0, 0, 1, 16'h0);
            chk("wrap_data", dout0, exp3[k]);
        end
        drv(0, 0, 0, 16'h0);

        // Flush with flags set and a same-cycle write.
        drv(0, 0, 1, 16'h0);
        chk("udf_empty_read", udf0, 1);
        drv(0, 1, 0, 16'h61); drv(0, 1, 0, 16'h62); drv(0, 1, 0, 16'h63);
        chk("pre_flush_count", cnt0, 3);
        flush[0] = 1'b1;
        drv(0, 1, 0, 16'h77);
        flush[0] = 1'b0;
        chk("flush_count", cnt0, 0);
        chk("flush_empty", empty0, 1);
        chk("flush_udf2", udf0, 0);
        chk("flush_valid", vld0, 0);
        drv(0, 1, 0, 16'h12);
        drv(0, 0, 1, 16'h0);
        chk("post_flush_data", dout0, 16'h12);

        // Clock-enable freeze.
        drv(0, 1, 0, 16'h21); drv(0, 1, 0, 16'h22); drv(0, 0, 0, 16'h0);
        clk_en[0] = 1'b0;
        repeat (3) drv(0, 1, 1, 16'h5A);
        chk("freeze_count", cnt0, 2);
        chk("freeze_valid", vld0, 0);
        chk("freeze_ovf", ovf0, 0);
        chk("freeze_udf", udf0, 0);
        clk_en[0] = 1'b1;
        drv(0, 0, 1, 16'h0);
        chk("unfreeze_data", dout0, 16'h21);

        // Asynchronous reset mid-stream.
        drv(0, 1, 1, 16'h31);
        chk("prerst_valid", vld0, 1);
        chk("prerst_data", dout0, 16'h22);
        #2;
        rst[0] = 1'b1;
        #1;
        chk("arst_valid", vld0, 0);
        chk("arst_count", cnt0, 0);
        chk("arst_data", dout0, 0);
        chk("arst_empty", empty0, 1);
        wen[0] = 1'b0;
        ren[0] = 1'b0;
        cyc();
        rst[0] = 1'b0;
        cyc();

        // DEPTH=5, READ_LATENCY=2 streaming with pointer wrap.
        obs1.delete();
        for (int c = 0; c < 16; c++) begin
            drv(1, c < 12, (c >= 2) && (c < 14), 16'h100 + 16'(c));
            if (c == 2) chk("lat2_not_yet", vld1, 0);
            if (c == 3) begin
                chk("lat2_first_valid", vld1, 1);
                chk("lat2_first_data", dout1, 16'h100);
            end
        end
        drv(1, 0, 0, 16'h0);
        chk("lat2_words", obs1.size(), 12);
        for (int k = 0; k < 12; k++) begin
            if (k < obs1.size()) chk("lat2_order", obs1[k], 32'h100 + 32'(k));
        end
        chk("lat2_empty", empty1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
